// File: rtl/id_stage_if.sv
// Fetch-to-decode, write-back and ID/EX boundary signals of the decode stage.
interface id_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [XLEN-1:0] pc_in;
  logic [31:0]     instr_in;
  logic            stall;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            illegal;

  modport master (
    output if_valid, pc_in, instr_in, stall, flush, wb_en, wb_rd, wb_data,
    input  id_valid, id_pc, rs1_data, rs2_data, imm, rd, rs1, rs2, opcode,
           funct3, funct7b5, reg_write, mem_read, mem_write, illegal
  );

  modport slave (
    input  if_valid, pc_in, instr_in, stall, flush, wb_en, wb_rd, wb_data,
    output id_valid, id_pc, rs1_data, rs2_data, imm, rd, rs1, rs2, opcode,
           funct3, funct7b5, reg_write, mem_read, mem_write, illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register file, decoder, immediate generator
// and the ID/EX pipeline register with stall, flush and write-back bypass.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic       clk,
  input  logic       reset,
  id_stage_if.slave  bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [XLEN-1:0] regs_r [NREGS];

  logic [31:0]     ins_s;
  logic [6:0]      opcode_s;
  logic [4:0]      rd_s;
  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [2:0]      funct3_s;
  logic            funct7b5_s;
  logic [XLEN-1:0] imm_s;
  logic            writes_rd_s;
  logic            reg_write_s;
  logic            mem_read_s;
  logic            mem_write_s;
  logic            illegal_s;
  logic            wb_write_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;

  logic            id_valid_r;
  logic [XLEN-1:0] id_pc_r;
  logic [XLEN-1:0] rs1_data_r;
  logic [XLEN-1:0] rs2_data_r;
  logic [XLEN-1:0] imm_r;
  logic [4:0]      rd_r;
  logic [4:0]      rs1_r;
  logic [4:0]      rs2_r;
  logic [6:0]      opcode_r;
  logic [2:0]      funct3_r;
  logic            funct7b5_r;
  logic            reg_write_r;
  logic            mem_read_r;
  logic            mem_write_r;
  logic            illegal_r;

  assign ins_s      = bus.instr_in;
  assign opcode_s   = ins_s[6:0];
  assign rd_s       = ins_s[11:7];
  assign funct3_s   = ins_s[14:12];
  assign rs1_s      = ins_s[19:15];
  assign rs2_s      = ins_s[24:20];
  assign funct7b5_s = ins_s[30];
  assign wb_write_s = bus.wb_en && (bus.wb_rd != 5'd0);

  // Opcode decode: immediate format and control bits.
  always_comb begin
    imm_s       = '0;
    writes_rd_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    illegal_s   = 1'b0;
    case (opcode_s)
      OP_LOAD: begin
        imm_s       = {{20{ins_s[31]}}, ins_s[31:20]};
        writes_rd_s = 1'b1;
        mem_read_s  = 1'b1;
      end
      OP_IMM, OP_JALR: begin
        imm_s       = {{20{ins_s[31]}}, ins_s[31:20]};
        writes_rd_s = 1'b1;
      end
      OP_STORE: begin
        imm_s       = {{20{ins_s[31]}}, ins_s[31:25], ins_s[11:7]};
        mem_write_s = 1'b1;
      end
      OP_BRANCH: begin
        imm_s = {{19{ins_s[31]}}, ins_s[31], ins_s[7], ins_s[30:25], ins_s[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm_s       = {ins_s[31:12], 12'h000};
        writes_rd_s = 1'b1;
      end
      OP_JAL: begin
        imm_s       = {{11{ins_s[31]}}, ins_s[31], ins_s[19:12], ins_s[20], ins_s[30:21], 1'b0};
        writes_rd_s = 1'b1;
      end
      OP_REG: begin
        writes_rd_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    reg_write_s = writes_rd_s && (rd_s != 5'd0);
  end

  // Operand read with write-first bypass from the same-cycle write-back.
  always_comb begin
    if (rs1_s == 5'd0) begin
      rs1_val_s = '0;
    end else if (wb_write_s && (bus.wb_rd == rs1_s)) begin
      rs1_val_s = bus.wb_data;
    end else begin
      rs1_val_s = regs_r[rs1_s];
    end
    if (rs2_s == 5'd0) begin
      rs2_val_s = '0;
    end else if (wb_write_s && (bus.wb_rd == rs2_s)) begin
      rs2_val_s = bus.wb_data;
    end else begin
      rs2_val_s = regs_r[rs2_s];
    end
  end

  // Register file write port; x0 is never written so it stays zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_write_s) begin
      regs_r[bus.wb_rd] <= bus.wb_data;
    end
  end

  // ID/EX boundary register: flush beats stall beats load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_r  <= 1'b0;
      id_pc_r     <= '0;
      rs1_data_r  <= '0;
      rs2_data_r  <= '0;
      imm_r       <= '0;
      rd_r        <= 5'd0;
      rs1_r       <= 5'd0;
      rs2_r       <= 5'd0;
      opcode_r    <= 7'd0;
      funct3_r    <= 3'd0;
      funct7b5_r  <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (bus.flush) begin
      id_valid_r  <= 1'b0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (bus.stall) begin
      // A held instruction must not keep a stale operand that write-back just produced.
      if (wb_write_s && (bus.wb_rd == rs1_r)) begin
        rs1_data_r <= bus.wb_data;
      end
      if (wb_write_s && (bus.wb_rd == rs2_r)) begin
        rs2_data_r <= bus.wb_data;
      end
    end else begin
      id_valid_r  <= bus.if_valid;
      id_pc_r     <= bus.pc_in;
      rs1_data_r  <= rs1_val_s;
      rs2_data_r  <= rs2_val_s;
      imm_r       <= imm_s;
      rd_r        <= rd_s;
      rs1_r       <= rs1_s;
      rs2_r       <= rs2_s;
      opcode_r    <= opcode_s;
      funct3_r    <= funct3_s;
      funct7b5_r  <= funct7b5_s;
      reg_write_r <= bus.if_valid && reg_write_s;
      mem_read_r  <= bus.if_valid && mem_read_s;
      mem_write_r <= bus.if_valid && mem_write_s;
      illegal_r   <= bus.if_valid && illegal_s;
    end
  end

  assign bus.id_valid  = id_valid_r;
  assign bus.id_pc     = id_pc_r;
  assign bus.rs1_data  = rs1_data_r;
  assign bus.rs2_data  = rs2_data_r;
  assign bus.imm       = imm_r;
  assign bus.rd        = rd_r;
  assign bus.rs1       = rs1_r;
  assign bus.rs2       = rs2_r;
  assign bus.opcode    = opcode_r;
  assign bus.funct3    = funct3_r;
  assign bus.funct7b5  = funct7b5_r;
  assign bus.reg_write = reg_write_r;
  assign bus.mem_read  = mem_read_r;
  assign bus.mem_write = mem_write_r;
  assign bus.illegal   = illegal_r;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: decode vector table plus stall, flush,
// x0 and asynchronous-reset sequences, checked through an expectation queue.
module tb_id_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_stage_if bus ();

  id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic        full;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b5;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
  } exp_t;

  vec_t        vecs [14];
  exp_t        exp_q [$];
  logic [31:0] model [32];
  int          errors = 0;
  int          checks = 0;

  function automatic vec_t mkvec(
    input logic [31:0] instr, input logic [31:0] pc,
    input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [6:0] opcode, input logic [2:0] funct3, input logic f7b5,
    input logic [31:0] imm, input logic rw, input logic mr, input logic mw, input logic ill);
    vec_t v;
    v.instr = instr; v.pc = pc; v.wb_en = wb_en; v.wb_rd = wb_rd; v.wb_data = wb_data;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.opcode = opcode; v.funct3 = funct3;
    v.f7b5 = f7b5; v.imm = imm; v.rw = rw; v.mr = mr; v.mw = mw; v.ill = ill;
    return v;
  endfunction

  // Architectural read: x0 is zero, a same-cycle write-back wins.
  function automatic logic [31:0] rd_model(input logic [4:0] idx, input logic wb_en,
                                           input logic [4:0] wb_rd, input logic [31:0] wb_data);
    if (idx == 5'd0) return 32'h0;
    if (wb_en && (wb_rd == idx)) return wb_data;
    return model[idx];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = exp_q.pop_front();
      chk("id_valid",  32'(bus.id_valid),  32'(e.valid));
      chk("reg_write", 32'(bus.reg_write), 32'(e.rw));
      chk("mem_read",  32'(bus.mem_read),  32'(e.mr));
      chk("mem_write", 32'(bus.mem_write), 32'(e.mw));
      chk("illegal",   32'(bus.illegal),   32'(e.ill));
      if (e.full) begin
        chk("id_pc",    bus.id_pc,           e.pc);
        chk("rs1_data", bus.rs1_data,        e.rs1_data);
        chk("rs2_data", bus.rs2_data,        e.rs2_data);
        chk("imm",      bus.imm,             e.imm);
        chk("rd",       32'(bus.rd),         32'(e.rd));
        chk("rs1",      32'(bus.rs1),        32'(e.rs1));
        chk("rs2",      32'(bus.rs2),        32'(e.rs2));
        chk("opcode",   32'(bus.opcode),     32'(e.opcode));
        chk("funct3",   32'(bus.funct3),     32'(e.funct3));
        chk("funct7b5", 32'(bus.funct7b5),   32'(e.f7b5));
      end
    end
  endtask

  // One clock: drive, queue the expectation, take the edge, update the model, compare.
  task automatic cycle(input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                       input logic stall, input logic flush, input logic wb_en,
                       input logic [4:0] wb_rd, input logic [31:0] wb_data, input exp_t e);
    bus.if_valid = valid;
    bus.instr_in = instr;
    bus.pc_in    = pc;
    bus.stall    = stall;
    bus.flush    = flush;
    bus.wb_en    = wb_en;
    bus.wb_rd    = wb_rd;
    bus.wb_data  = wb_data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (wb_en && (wb_rd != 5'd0)) model[wb_rd] = wb_data;
    check_out();
  endtask

  task automatic apply_vec(input vec_t v, output exp_t e);
    e.full = 1'b1; e.valid = 1'b1; e.pc = v.pc;
    e.rs1_data = rd_model(v.rs1, v.wb_en, v.wb_rd, v.wb_data);
    e.rs2_data = rd_model(v.rs2, v.wb_en, v.wb_rd, v.wb_data);
    e.imm = v.imm; e.rd = v.rd; e.rs1 = v.rs1; e.rs2 = v.rs2; e.opcode = v.opcode;
    e.funct3 = v.funct3; e.f7b5 = v.f7b5; e.rw = v.rw; e.mr = v.mr; e.mw = v.mw; e.ill = v.ill;
    cycle(1'b1, v.instr, v.pc, 1'b0, 1'b0, v.wb_en, v.wb_rd, v.wb_data, e);
  endtask

  task automatic wb_write(input logic [4:0] idx, input logic [31:0] data);
    exp_t e;
    e = '0;
    cycle(1'b0, 32'h0000_0013, 32'h0, 1'b0, 1'b0, 1'b1, idx, data, e);
  endtask

  initial begin
    exp_t e;
    exp_t held;
    exp_t zero_e;

    //                 instr          pc          wb  rd     data          rd     rs1    rs2    opcode      f3    b5    imm           rw    mr    mw    ill
    vecs[0]  = mkvec(32'h0050_0093, 32'h100, 1'b0, 5'd0, 32'h0,        5'd1,  5'd0,  5'd5,  7'h13, 3'd0, 1'b0, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mkvec(32'h0020_81B3, 32'h104, 1'b0, 5'd0, 32'h0,        5'd3,  5'd1,  5'd2,  7'h33, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mkvec(32'h0020_81B3, 32'h108, 1'b1, 5'd1, 32'hCAFEF00D, 5'd3,  5'd1,  5'd2,  7'h33, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mkvec(32'h0081_2283, 32'h10C, 1'b1, 5'd5, 32'h77,       5'd5,  5'd2,  5'd8,  7'h03, 3'd2, 1'b0, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mkvec(32'h1234_53B7, 32'h110, 1'b0, 5'd0, 32'h0,        5'd7,  5'd8,  5'd3,  7'h37, 3'd5, 1'b0, 32'h1234_5000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mkvec(32'hFE00_0EE3, 32'h114, 1'b0, 5'd0, 32'h0,        5'd29, 5'd0,  5'd0,  7'h63, 3'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mkvec(32'h0010_00EF, 32'h118, 1'b0, 5'd0, 32'h0,        5'd1,  5'd0,  5'd1,  7'h6F, 3'd0, 1'b0, 32'h0000_0800, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mkvec(32'h0000_006F, 32'h11C, 1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  5'd0,  7'h6F, 3'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mkvec(32'hFFFF_F517, 32'h120, 1'b0, 5'd0, 32'h0,        5'd10, 5'd31, 5'd31, 7'h17, 3'd7, 1'b1, 32'hFFFF_F000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mkvec(32'hFFF1_00E7, 32'h124, 1'b1, 5'd2, 32'h1111,     5'd1,  5'd2,  5'd31, 7'h67, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[10] = mkvec(32'h4011_8233, 32'h128, 1'b0, 5'd0, 32'h0,        5'd4,  5'd3,  5'd1,  7'h33, 3'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[11] = mkvec(32'hFE20_AE23, 32'h12C, 1'b0, 5'd0, 32'h0,        5'd28, 5'd1,  5'd2,  7'h23, 3'd2, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[12] = mkvec(32'h0050_0093, 32'h130, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd1,  5'd0,  5'd5,  7'h13, 3'd0, 1'b0, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[13] = mkvec(32'hFFFF_FFFF, 32'h134, 1'b0, 5'd0, 32'h0,        5'd31, 5'd31, 5'd31, 7'h7F, 3'd7, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    zero_e = '0;
    zero_e.full = 1'b1;

    // Reset with a valid instruction presented: outputs must stay zero.
    reset = 1'b1;
    bus.if_valid = 1'b1; bus.instr_in = 32'h0050_0093; bus.pc_in = 32'h100;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.wb_en = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
    @(posedge clk);
    #1;
    exp_q.push_back(zero_e);
    check_out();
    reset = 1'b0;

    apply_vec(vecs[0], e);
    wb_write(5'd1, 32'h1234_5678);
    wb_write(5'd2, 32'h0000_000A);
    for (int i = 1; i <= 11; i++) apply_vec(vecs[i], e);
    held = e;

    // Stall on the store: held, except rs2_data refreshed by the x2 write-back.
    cycle(1'b1, 32'h0050_0093, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, held);
    held.rs2_data = 32'h0000_0055;
    cycle(1'b1, 32'h0050_0093, 32'h204, 1'b1, 1'b0, 1'b1, 5'd2, 32'h55, held);
    cycle(1'b1, 32'h0050_0093, 32'h208, 1'b1, 1'b0, 1'b1, 5'd5, 32'h99, held);

    // Flush wins over stall.
    e = '0;
    cycle(1'b1, 32'h0050_0093, 32'h20C, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, e);

    wb_write(5'd0, 32'hFFFF_FFFF);
    apply_vec(vecs[12], e);
    apply_vec(vecs[13], e);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    #3;
    reset = 1'b1;
    #1;
    exp_q.push_back(zero_e);
    check_out();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply_vec(vecs[1], e);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the three-stage RV32I pipeline. Sits directly downstream of instruction fetch and consumes its `pc_current` / `Instruction` pair.
- Holds the 32x32 integer register file, decodes the instruction and generates the immediate.
- Registers operands and controls into the ID/EX boundary for the execute/memory stage.
- Handles stall, flush and write-back bypass.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, number of architectural registers (x0 hardwired to zero).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_valid  input  1  fetch presents a valid instruction this cycle.
- pc_in  input  32  PC of the fetched instruction (from `pc_current`).
- instr_in  input  32  fetched instruction word.
- stall  input  1  hold ID/EX outputs unchanged.
- flush  input  1  squash the instruction entering ID/EX.
- wb_en  input  1  register-file write enable from write-back.
- wb_rd  input  5  write-back destination index.
- wb_data  input  32  write-back data.
- id_valid  output  1  ID/EX slot holds a valid instruction.
- id_pc  output  32  PC of the held instruction.
- rs1_data, rs2_data  output  32 each  source operands.
- imm  output  32  sign-extended immediate.
- rd, rs1, rs2  output  5 each  register indices.
- opcode  output  7  opcode field.
- funct3  output  3  funct3 field.
- funct7b5  output  1  instr[30].
- reg_write, mem_read, mem_write  output  1 each  control bits.
- illegal  output  1  unsupported opcode.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0.
  - All 32 registers are cleared.
  - Reset asserted mid-operation discards the held instruction immediately.
- Latency: 1 cycle. Decode of `instr_in` at edge N appears on outputs after edge N.
- Update priority per rising edge:
  - flush: id_valid<=0 and reg_write/mem_read/mem_write/illegal<=0; other fields don't-care.
  - else stall: all outputs held.
  - else load: id_valid<=if_valid plus the decoded fields. When if_valid=0, all control bits are loaded as 0.
- Register file:
  - Write on rising edge when wb_en=1 and wb_rd!=0. Writes to x0 are ignored; x0 always reads 0.
  - Writes proceed regardless of stall and flush.
- Read bypass: if wb_en=1, wb_rd!=0 and wb_rd equals the source index in the same cycle, operand = wb_data (write-first).
- Stall refresh: while stall=1 and not flush, if a write-back targets the held rs1 (or rs2) and that index is non-zero, rs1_data (rs2_data) updates to wb_data at that edge.
- Immediate by opcode:
  - I (0000011, 0010011, 1100111): {{20{i[31]}}, i[31:20]}.
  - S (0100011): {{20{i[31]}}, i[31:25], i[11:7]}.
  - B (1100011): {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 0}.
  - U (0110111, 0010111): {i[31:12], 12'b0}.
  - J (1101111): {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 0}.
  - R (0110011): 0.
- Controls:
  - reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, only when rd!=0.
  - mem_read=1 for LOAD only.
  - mem_write=1 for STORE only.
- Any other opcode: illegal=1 and all three controls 0. id_valid still follows if_valid.
- Field outputs (rd/rs1/rs2/funct3/funct7b5) are the raw instruction slices, regardless of format.

Test Plan:
- Reset then release, instr_in=0x00500093 (ADDI x1,x0,5), if_valid=1, pc_in=0x100 -> next cycle: id_valid=1, id_pc=0x100, rd=1, rs1=0, rs1_data=0, imm=5, reg_write=1, illegal=0.
- wb x1=0x12345678, wb x2=0x0000000A on prior cycles; load 0x002081B3 (ADD x3,x1,x2) -> rs1_data=0x12345678, rs2_data=0xA, imm=0, rd=3, reg_write=1.
- Same-cycle bypass: wb_en=1, wb_rd=1, wb_data=0xCAFEF00D while loading 0x002081B3 -> rs1_data=0xCAFEF00D.
- Load 0xFE20AE23 (SW x2,-4(x1)) -> imm=0xFFFFFFFC, mem_write=1, reg_write=0, funct3=2. Then stall=1 for 3 cycles with wb x2=0x55 during the stall -> outputs held except rs2_data=0x55.
- Flush and stall together with valid ADDI input -> id_valid=0, reg_write=0. Then wb x0=0xFFFFFFFF and read x0 -> rs1_data=0.
- instr_in=0xFFFFFFFF, if_valid=1 -> illegal=1, reg_write=mem_read=mem_write=0. Assert reset asynchronously mid-cycle -> all outputs 0 before the next edge.
